alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request present.
REQ-005 SHALL have port: in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port: alu_control  input  3  operation code from the ALU control decoder.
REQ-007 SHALL have port: op_a  input  WIDTH  first operand (rs1).
REQ-008 SHALL have port: op_b  input  WIDTH  second operand (rs2 or immediate).
REQ-009 SHALL have port: out_valid  output  1  result present.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result this cycle.
REQ-011 SHALL have port: result  output  WIDTH  registered ALU result.
REQ-012 SHALL have port: zero  output  1  high when result == 0.
REQ-013 SHALL have port: branch_taken  output  1  branch condition true, for branch codes only.
REQ-014 SHALL have port: illegal  output  1  request carried an unsupported code.

Function
REQ-015 SHALL decode alu_control: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 BLT (signed a<b), 101 BGE (signed a>=b), 110 BEQ (a==b), 111 illegal.
REQ-016 SHALL compute ADD/SUB modulo 2^WIDTH; carry and overflow are discarded.
REQ-017 SHALL, for branch codes, set result = {WIDTH-1 zeros, taken} and branch_taken = taken.
REQ-018 SHALL, for non-branch codes, drive branch_taken = 0.
REQ-019 SHALL, for code 111, drive result = 0, zero = 1, branch_taken = 0, and illegal = 1.
REQ-020 SHALL, for legal codes, drive illegal = 0.
REQ-021 SHALL be a two-stage pipeline: S1 registers {alu_control, op_a, op_b}; S2 registers {result, zero, branch_taken, illegal}.
REQ-022 SHALL accept a request on a cycle where in_valid && in_ready.
REQ-023 SHALL transfer a result on a cycle where out_valid && out_ready.
REQ-024 SHALL load S2 when s1_valid && (!s2_valid || out_ready).
REQ-025 SHALL drive in_ready = !s1_valid || S2-load condition; a combinational path from out_ready to in_ready is permitted.
REQ-026 SHALL present out_valid exactly 2 cycles after acceptance when unstalled.
REQ-027 SHALL sustain throughput of 1 operation per cycle while out_ready stays high.
REQ-028 SHALL hold result, zero, branch_taken and illegal stable while out_valid && !out_ready.
REQ-029 SHALL neither drop nor duplicate results under any out_ready pattern; results leave in acceptance order.
REQ-030 SHALL update S1 with the new request and S2 with the old S1 contents in the same cycle when accept, S2 load and output transfer coincide.
REQ-031 SHALL deassert in_ready when S1 and S2 are both full and out_ready = 0.
REQ-032 SHALL ignore op_a, op_b and alu_control on cycles where in_valid = 0 or in_ready = 0.

Reset
REQ-033 SHALL, while rst_n = 0, asynchronously clear s1_valid and s2_valid, and drive out_valid = 0, result = 0, zero = 0, branch_taken = 0 and illegal = 0.
REQ-034 SHALL drive in_ready = 1 during reset.
REQ-035 SHALL discard in-flight operations when reset asserts mid-operation; they never appear at the output.
REQ-036 SHALL accept a request on the first rising edge after rst_n deasserts.

Verification
REQ-037 Bench SHALL cover: ADD 0xFFFFFFFF + 0x00000001, out_ready = 1 -> 2 cycles later out_valid = 1, result = 0, zero = 1.
REQ-038 Bench SHALL cover: SUB 5 - 7; then AND 0xF0F0F0F0 & 0x0FF00FF0; then OR of the same operands, back-to-back -> results 0xFFFFFFFE, 0x00F000F0, 0xFFF0FFF0 on consecutive cycles.
REQ-039 Bench SHALL cover: BLT 0x80000000 vs 0x7FFFFFFF; then BGE with the same operands; then BEQ 3 vs 3 -> branch_taken 1, 0, 1; result 1, 0, 1.
REQ-040 Bench SHALL cover: code 111 with op_a = op_b = 0x12345678 -> illegal = 1, result = 0, zero = 1, branch_taken = 0.
REQ-041 Bench SHALL cover: out_ready held low for 4 cycles while 3 requests are offered -> in_ready drops after 2 accepts, output stays stable, and both results then drain in order with the third accepted.
REQ-042 Bench SHALL cover: rst_n pulsed low for 1 cycle with both stages full -> out_valid = 0 immediately, no stale result after release, in_ready = 1.

Source files
------------

// File: rtl/alu_exec.sv
// Two-stage pipelined ALU/branch-compare unit with valid/ready flow control.
// S1 captures the request; S2 holds the computed result until the consumer takes it.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken,
    output logic             illegal
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_BLT = 3'b100,
        OP_BGE = 3'b101,
        OP_BEQ = 3'b110,
        OP_ILL = 3'b111
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q;
    logic             s2_zero_q, s2_taken_q, s2_illegal_q;

    logic             accept, s2_load, transfer;
    logic [WIDTH-1:0] alu_res;
    logic             alu_taken, alu_illegal;

    // Handshake: a request moves on a cycle with in_valid && in_ready, a result
    // leaves on a cycle with out_valid && out_ready; S2 refills in the same cycle it drains.
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;
    assign transfer = s2_valid_q && out_ready;

    always_comb begin
        alu_res     = '0;
        alu_taken   = 1'b0;
        alu_illegal = 1'b0;
        case (s1_op_q)
            OP_AND: alu_res = s1_a_q & s1_b_q;
            OP_OR:  alu_res = s1_a_q | s1_b_q;
            OP_ADD: alu_res = s1_a_q + s1_b_q;
            OP_SUB: alu_res = s1_a_q - s1_b_q;
            OP_BLT: alu_taken = $signed(s1_a_q) < $signed(s1_b_q);
            OP_BGE: alu_taken = $signed(s1_a_q) >= $signed(s1_b_q);
            OP_BEQ: alu_taken = (s1_a_q == s1_b_q);
            default: alu_illegal = 1'b1;
        endcase
        // Branch codes report the outcome in bit 0 of the result as well.
        if (alu_taken) begin
            alu_res = {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (transfer) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_AND;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_op_q <= op_e'(alu_control);
                s1_a_q  <= op_a;
                s1_b_q  <= op_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_zero_q    <= 1'b0;
            s2_taken_q   <= 1'b0;
            s2_illegal_q <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                s2_result_q  <= alu_res;
                s2_zero_q    <= (alu_res == '0);
                s2_taken_q   <= alu_taken;
                s2_illegal_q <= alu_illegal;
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign result       = s2_result_q;
    assign zero         = s2_zero_q;
    assign branch_taken = s2_taken_q;
    assign illegal      = s2_illegal_q;

endmodule
